// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU op codes, issue payload type and carry-writer classification
package alu_issue_pkg;
  localparam int kAluW = 9;
  localparam logic [2:0] kAdd       = 3'b000;
  localparam logic [2:0] kSub       = 3'b001;
  localparam logic [2:0] kAddC      = 3'b010;
  localparam logic [2:0] kAnd       = 3'b011;
  localparam logic [2:0] kOr        = 3'b100;
  localparam logic [2:0] kXor       = 3'b101;
  localparam logic [2:0] kIllegalOp = 3'b110;
  localparam logic [2:0] kPass      = 3'b111;
  typedef struct packed {
    logic [2:0]       op;
    logic [kAluW-1:0] a;
    logic [kAluW-1:0] b;
  } alu_issue_t;
  function automatic logic writes_carry(input logic [2:0] op);
    return (op == kAdd) || (op == kAddC) || (op == kSub);
  endfunction
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry in-order skid buffer with registered ready
module alu_skid_buf
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  alu_issue_t pushData,
  input  logic       pop,
  output logic       headValid,
  output alu_issue_t head,
  output logic       inReady
);
  typedef enum logic [1:0] {sEmpty, sOne, sTwo} bufState_t;
  bufState_t  state, nextState;
  alu_issue_t tail;
  // occupancy transition; ready is derived from where we land
  always_comb
    nextState = (state == sEmpty) ? (push ? sOne : sEmpty) :
                (state == sOne)   ? ((push && !pop) ? sTwo : (pop && !push) ? sEmpty : sOne) :
                (pop ? sOne : sTwo);
  // occupancy, registered ready and the two payload slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= sEmpty;
      inReady <= 1'b1;
      head    <= '0;
      tail    <= '0;
    end else begin
      state   <= nextState;
      inReady <= (nextState != sTwo);
      if (state == sTwo && pop) head <= tail;
      else if (push && (state == sEmpty || pop)) head <= pushData;
      if (push && state == sOne && !pop) tail <= pushData;
    end
  end
  assign headValid = (state != sEmpty);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-ALU issue with carry-flag ownership; ALU_ISSUE_STATS_EN adds stat counters
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int W            = kAluW,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_op,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_cin,
  input  logic         alu_cout_valid,
  input  logic         alu_cout,
  output logic         illegal_op,
  output logic         carry_err
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]  stat_issued,
  output logic [31:0]  stat_stalls
`endif
);
  localparam int kPw = $clog2(MAX_INFLIGHT + 1);
  localparam logic [kPw-1:0] kMax = kPw'(MAX_INFLIGHT);
  localparam logic [kPw-1:0] kOne = kPw'(1);
  alu_issue_t    head;
  logic          headValid, accept, push, issue, issueWr;
  logic          pendNz, coutOk, fwd, hazard, full, blk;
  logic [kPw-1:0] pending;
  logic          carryQ;
  assign accept  = in_valid && in_ready;
  assign push    = accept && (in_op != kIllegalOp);
  alu_skid_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData ('{op: in_op, a: in_a, b: in_b}),
    .pop      (issue),
    .headValid(headValid),
    .head     (head),
    .inReady  (in_ready)
  );
  assign pendNz  = (pending != '0);
  assign coutOk  = alu_cout_valid && pendNz;
  assign fwd     = (pending == kOne) && alu_cout_valid;
  assign hazard  = (head.op == kAddC) && pendNz && !fwd;
  assign full    = writes_carry(head.op) && (pending == kMax) && !alu_cout_valid;
  assign blk     = hazard || full;
  assign out_valid = headValid && !blk;
  assign issue   = out_valid && out_ready;
  assign issueWr = issue && writes_carry(head.op);
  assign out_op  = head.op;
  assign out_a   = head.a;
  assign out_b   = head.b;
  assign out_cin = fwd ? alu_cout : carryQ;
  // carry scoreboard, architectural carry and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      carryQ     <= 1'b0;
      illegal_op <= 1'b0;
      carry_err  <= 1'b0;
    end else begin
      pending    <= pending + kPw'(issueWr && !coutOk) - kPw'(coutOk && !issueWr);
      if (coutOk) carryQ <= alu_cout;
      illegal_op <= accept && (in_op == kIllegalOp);
      carry_err  <= alu_cout_valid && !pendNz;
    end
  end
`ifdef ALU_ISSUE_STATS_EN
  // issue and stall-cycle counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      stat_issued <= stat_issued + 32'(issue);
      stat_stalls <= stat_stalls + 32'(headValid && blk);
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard-based bench for alu_issue_stage
module tb_alu_issue_stage;
  import alu_issue_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, alu_cout_valid = 1'b0, alu_cout = 1'b0;
  logic [2:0] in_op = '0;
  logic [8:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cin, illegal_op, carry_err;
  logic [2:0] out_op;
  logic [8:0] out_a, out_b;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stalls;
`endif
  int compared = 0, mismatched = 0, accCnt = 0, issCnt = 0;
  logic [20:0] sb[$];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_cin(out_cin), .alu_cout_valid(alu_cout_valid), .alu_cout(alu_cout),
    .illegal_op(illegal_op), .carry_err(carry_err)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // scoreboard: push on accepted legal ops, pop and compare on issue
  always @(negedge clk) begin
    logic [20:0] exp;
    #4;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        accCnt++;
        if (in_op != kIllegalOp) sb.push_back({in_op, in_a, in_b});
      end
      if (out_valid && out_ready) begin
        issCnt++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL issue_order: got op=%0d a=%0h b=%0h, required no issue (queue empty)", out_op, out_a, out_b);
        end else begin
          exp = sb.pop_front();
          if ({out_op, out_a, out_b} !== exp) begin
            mismatched++;
            $display("FAIL issue_order: got %h, required %h", {out_op, out_a, out_b}, exp);
          end
        end
      end
    end
  end

  task automatic setIn(input logic v, input logic [2:0] op, input logic [8:0] a, input logic [8:0] b);
    in_valid = v; in_op = op; in_a = a; in_b = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    compared++; if ({out_op, out_a, out_b, out_cin} !== 22'd0) begin mismatched++; $display("FAIL reset_out_bus: got %h, required 0", {out_op, out_a, out_b, out_cin}); end
    compared++; if ({illegal_op, carry_err} !== 2'b00) begin mismatched++; $display("FAIL reset_pulses: got %b, required 00", {illegal_op, carry_err}); end
  endtask

  task automatic test_basic;
    @(negedge clk); setIn(1, kAdd, 9'h005, 9'h003); out_ready = 1'b1;
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %b, required 1", out_valid); end
    compared++; if ({out_op, out_a, out_b} !== {kAdd, 9'h005, 9'h003}) begin mismatched++; $display("FAIL basic_payload: got %h, required %h", {out_op, out_a, out_b}, {kAdd, 9'h005, 9'h003}); end
    compared++; if (out_cin !== 1'b0) begin mismatched++; $display("FAIL basic_cin: got %b, required 0", out_cin); end
    @(negedge clk); alu_cout_valid = 1'b1; alu_cout = 1'b0;
    @(negedge clk); alu_cout_valid = 1'b0; #1;
    compared++; if (carry_err !== 1'b0) begin mismatched++; $display("FAIL basic_carry_err: got %b, required 0", carry_err); end
  endtask

  task automatic test_backpressure;
    int base, iss, n;
    @(negedge clk); out_ready = 1'b0; setIn(1, kAnd, 9'h001, 9'h002); base = accCnt; iss = issCnt;
    @(negedge clk); setIn(1, kOr, 9'h003, 9'h004); #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_one: got %b, required 1", in_ready); end
    @(negedge clk); setIn(1, kXor, 9'h005, 9'h006); #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_two: got %b, required 0", in_ready); end
    compared++; if (accCnt !== base + 2) begin mismatched++; $display("FAIL bp_accepted: got %0d, required %0d", accCnt - base, 2); end
    compared++; if (out_op !== kAnd) begin mismatched++; $display("FAIL bp_head: got %0d, required %0d", out_op, kAnd); end
    @(negedge clk); #1;
    compared++; if ({in_ready, out_valid} !== 2'b01) begin mismatched++; $display("FAIL bp_hold: got %b, required 01", {in_ready, out_valid}); end
    out_ready = 1'b1;
    n = 0;
    while (accCnt < base + 3 && n < 10) begin @(negedge clk); n++; end
    setIn(0, 3'd0, 9'd0, 9'd0);
    n = 0;
    while (issCnt < iss + 3 && n < 10) begin @(negedge clk); n++; end
    #1;
    compared++; if (issCnt !== iss + 3) begin mismatched++; $display("FAIL bp_drain: got %0d issued, required 3", issCnt - iss); end
    compared++; if ({out_valid, in_ready} !== 2'b01 || sb.size() != 0) begin mismatched++; $display("FAIL bp_empty: got valid/ready %b queue %0d, required 01 and 0", {out_valid, in_ready}, sb.size()); end
  endtask

  task automatic test_carry_hazard;
    @(negedge clk); out_ready = 1'b1; setIn(1, kAdd, 9'h001, 9'h002);
    @(negedge clk); setIn(1, kAddC, 9'h003, 9'h004);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if ({out_valid, out_op} !== {1'b0, kAddC}) begin mismatched++; $display("FAIL hazard_stall%0d: got valid=%b op=%0d, required 0/%0d", i, out_valid, out_op, kAddC); end
      @(negedge clk);
    end
    alu_cout_valid = 1'b1; alu_cout = 1'b1; #1;
    compared++; if ({out_valid, out_cin} !== 2'b11) begin mismatched++; $display("FAIL hazard_forward: got valid/cin %b, required 11", {out_valid, out_cin}); end
    @(negedge clk);
    @(negedge clk); alu_cout_valid = 1'b0; #1;
    compared++; if ({out_valid, carry_err} !== 2'b00) begin mismatched++; $display("FAIL hazard_done: got %b, required 00", {out_valid, carry_err}); end
  endtask

  task automatic test_full;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stallBase, issBase;
`endif
    @(negedge clk); out_ready = 1'b1; alu_cout = 1'b1; setIn(1, kAdd, 9'h005, 9'h005);
    @(negedge clk); setIn(1, kSub, 9'h006, 9'h001);
    @(negedge clk); setIn(1, kSub, 9'h007, 9'h002);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
`ifdef ALU_ISSUE_STATS_EN
    stallBase = stat_stalls; issBase = stat_issued;
`endif
    compared++; if ({out_valid, out_op, out_a} !== {1'b0, kSub, 9'h007}) begin mismatched++; $display("FAIL full_stall: got valid=%b op=%0d a=%h, required 0/%0d/007", out_valid, out_op, out_a, kSub); end
    repeat (2) begin
      @(negedge clk); #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL full_hold: got %b, required 0", out_valid); end
    end
    @(negedge clk); alu_cout_valid = 1'b1; #1;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL full_release: got %b, required 1", out_valid); end
`ifdef ALU_ISSUE_STATS_EN
    compared++; if (stat_stalls - stallBase !== 32'd3) begin mismatched++; $display("FAIL stat_stalls: got %0d, required 3", stat_stalls - stallBase); end
    compared++; if (stat_issued !== issBase) begin mismatched++; $display("FAIL stat_issued: got %0d, required %0d", stat_issued, issBase); end
`endif
    repeat (3) @(negedge clk);
    alu_cout_valid = 1'b0; #1;
    compared++; if ({out_valid, carry_err} !== 2'b00) begin mismatched++; $display("FAIL full_done: got %b, required 00", {out_valid, carry_err}); end
  endtask

  task automatic test_illegal_carry_err;
    @(negedge clk); out_ready = 1'b1; setIn(1, kIllegalOp, 9'h007, 9'h007);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
    compared++; if ({illegal_op, out_valid} !== 2'b10) begin mismatched++; $display("FAIL illegal_pulse: got %b, required 10", {illegal_op, out_valid}); end
    @(negedge clk); #1;
    compared++; if ({illegal_op, out_valid} !== 2'b00) begin mismatched++; $display("FAIL illegal_clear: got %b, required 00", {illegal_op, out_valid}); end
    @(negedge clk); alu_cout_valid = 1'b1; alu_cout = 1'b0;
    @(negedge clk); alu_cout_valid = 1'b0; #1;
    compared++; if (carry_err !== 1'b1) begin mismatched++; $display("FAIL carry_err_pulse: got %b, required 1", carry_err); end
    @(negedge clk); #1;
    compared++; if (carry_err !== 1'b0) begin mismatched++; $display("FAIL carry_err_clear: got %b, required 0", carry_err); end
    out_ready = 1'b0; setIn(1, kAddC, 9'h002, 9'h002);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
    compared++; if ({out_valid, out_cin} !== 2'b11) begin mismatched++; $display("FAIL carry_kept: got valid/cin %b, required 11", {out_valid, out_cin}); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; alu_cout_valid = 1'b1; alu_cout = 1'b1;
    @(negedge clk); alu_cout_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); out_ready = 1'b1; setIn(1, kAdd, 9'h001, 9'h001);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0);
    @(negedge clk); out_ready = 1'b0; setIn(1, kAnd, 9'h008, 9'h009);
    @(negedge clk); setIn(1, kOr, 9'h00a, 9'h00b);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
    compared++; if ({in_ready, out_valid, out_op} !== {2'b01, kAnd}) begin mismatched++; $display("FAIL mid_two: got ready=%b valid=%b op=%0d, required 0/1/%0d", in_ready, out_valid, out_op, kAnd); end
    @(negedge clk); rst_n = 1'b0; sb.delete();
    @(negedge clk); rst_n = 1'b1; #1;
    compared++; if ({out_valid, in_ready, out_op} !== {2'b01, 3'd0}) begin mismatched++; $display("FAIL mid_reset: got valid=%b ready=%b op=%0d, required 0/1/0", out_valid, in_ready, out_op); end
    setIn(1, kAddC, 9'h004, 9'h004);
    @(negedge clk); setIn(0, 3'd0, 9'd0, 9'd0); #1;
    compared++; if ({out_valid, out_cin} !== 2'b10) begin mismatched++; $display("FAIL mid_pending_cleared: got valid/cin %b, required 10", {out_valid, out_cin}); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; alu_cout_valid = 1'b1; alu_cout = 1'b0;
    @(negedge clk); alu_cout_valid = 1'b0; #1;
    compared++; if ({out_valid, carry_err} !== 2'b00) begin mismatched++; $display("FAIL mid_done: got %b, required 00", {out_valid, carry_err}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_carry_hazard;
    test_full;
    test_illegal_carry_err;
    test_reset_mid;
    @(negedge clk); #1;
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL final_queue: got %0d pending ops, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
